pc_fetch_sequencer: RTL and testbench

Next-address controller for the program counter register, which loads next_address unconditionally every clock. Selects sequential, branch, jump or exception-vector address, and holds the PC by feeding back current_address. Sequences instruction-memory fetches with a req/ack handshake. Buffers redirects that arrive while a fetch is outstanding, and handles halt and interrupt entry.

---
 rtl/pc_fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Next-address controller for the PC register: sequential/branch/jump/vector
// selection, fetch handshake, buffered redirects, halt and interrupt entry.
module pc_fetch_sequencer #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(12'h180),
  parameter int                    PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  halt,
  input  logic                  irq,
  output logic                  irq_ack,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic                  halted
);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HALTED = 2'd2} state_t;

  state_t                state;
  logic [1:0]            pend_rank;
  logic [ADDR_WIDTH-1:0] pend_tgt;
  logic                  irq_armed;

  logic [1:0]            live_rank;
  logic [ADDR_WIDTH-1:0] live_tgt;
  logic [1:0]            eff_rank;
  logic [ADDR_WIDTH-1:0] eff_tgt;
  logic                  advance;
  logic                  take_irq;
  logic                  go_halt;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] seq_pc;

  assign seq_pc  = current_address + ADDR_WIDTH'(PC_STEP);
  assign advance = (state == FETCH) && imem_ack && !stall;

  // Rank the live redirect request; an interrupt only counts while armed.
  always_comb begin
    live_rank = 2'd0;
    live_tgt  = '0;
    if (irq && irq_armed) begin
      live_rank = 2'd3;
      live_tgt  = EXC_VECTOR;
    end else if (jump) begin
      live_rank = 2'd2;
      live_tgt  = jump_target;
    end else if (branch_taken) begin
      live_rank = 2'd1;
      live_tgt  = branch_target;
    end else begin
      live_rank = 2'd0;
      live_tgt  = '0;
    end
  end

  // Pick the effective redirect (a tie favours the live request) and the next PC.
  always_comb begin
    if (live_rank >= pend_rank) begin
      eff_rank = live_rank;
      eff_tgt  = live_tgt;
    end else begin
      eff_rank = pend_rank;
      eff_tgt  = pend_tgt;
    end
    next_pc  = current_address;
    take_irq = 1'b0;
    go_halt  = 1'b0;
    case (state)
      BOOT: next_pc = RESET_VECTOR;
      FETCH: begin
        if (!advance) begin
          next_pc = current_address;
        end else if (eff_rank != 2'd0) begin
          next_pc  = eff_tgt;
          take_irq = (eff_rank == 2'd3);
        end else if (halt) begin
          next_pc = current_address;
          go_halt = 1'b1;
        end else begin
          next_pc = seq_pc;
        end
      end
      HALTED: begin
        if (irq && irq_armed) begin
          next_pc  = EXC_VECTOR;
          take_irq = 1'b1;
        end else begin
          next_pc = current_address;
        end
      end
      default: next_pc = RESET_VECTOR;
    endcase
  end

  // The next-address path feeds the PC register directly so redirects land in one cycle.
  assign next_address = next_pc;
  assign irq_ack      = take_irq;
  assign imem_req     = (state == FETCH);
  assign halted       = (state == HALTED);

  // Sequencer state, redirect buffer, interrupt arming and saved PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pend_rank <= 2'd0;
      pend_tgt  <= '0;
      irq_armed <= 1'b1;
      epc       <= '0;
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (advance) begin
            pend_rank <= 2'd0;
            pend_tgt  <= '0;
            if (go_halt) state <= HALTED;
          end else if (live_rank > pend_rank) begin
            pend_rank <= live_rank;
            pend_tgt  <= live_tgt;
          end
        end
        HALTED: if (take_irq) state <= FETCH;
        default: state <= BOOT;
      endcase
      // Re-arm only after irq has been seen low, so a held level does not re-enter.
      if (take_irq) begin
        epc       <= current_address;
        irq_armed <= 1'b0;
      end else if (!irq) begin
        irq_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed and randomized bench for pc_fetch_sequencer with a behavioural
// reference model and an in-bench PC register.
module tb_pc_fetch_sequencer;

  localparam int RV  = 0;
  localparam int EXC = 'h180;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] current_address;
  logic [11:0] next_address;
  logic        imem_req, imem_ack, stall, branch_taken, jump, halt, irq;
  logic        irq_ack, halted;
  logic [11:0] branch_target, jump_target, epc;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_boot, m_halt, m_armed;
  int m_prank, m_ptgt, m_epc, m_pc;

  pc_fetch_sequencer dut (
    .clk(clk), .rst(rst), .current_address(current_address),
    .next_address(next_address), .imem_req(imem_req), .imem_ack(imem_ack),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .halt(halt), .irq(irq),
    .irq_ack(irq_ack), .epc(epc), .halted(halted)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst)
    if (rst) current_address <= 12'h000;
    else     current_address <= next_address;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_boot = 1; m_halt = 0; m_armed = 1;
    m_prank = 0; m_ptgt = 0; m_epc = 0; m_pc = 0;
  endtask

  // One clock of stimulus, checked against the model before the edge.
  task automatic cyc(input bit a, input bit s, input bit b, input int bt,
                     input bit j, input int jt, input bit h, input bit q);
    int lr, lt, er, et, nx;
    bit xa, adv;
    imem_ack = a; stall = s; branch_taken = b; branch_target = 12'(bt);
    jump = j; jump_target = 12'(jt); halt = h; irq = q;
    @(negedge clk);
    lr = 0; lt = 0; er = 0; et = 0; xa = 0; adv = 0; nx = m_pc;
    if (q && m_armed) begin lr = 3; lt = EXC; end
    else if (j)       begin lr = 2; lt = jt & 'hFFF; end
    else if (b)       begin lr = 1; lt = bt & 'hFFF; end
    if (m_boot) nx = RV;
    else if (m_halt) begin
      if (q && m_armed) begin nx = EXC; xa = 1; end
    end else if (a && !s) begin
      adv = 1;
      if (lr >= m_prank) begin er = lr; et = lt; end
      else begin er = m_prank; et = m_ptgt; end
      if (er > 0) begin nx = et; xa = (er == 3); end
      else if (!h) nx = (m_pc + 4) % 4096;
    end
    chk("pc", current_address, m_pc);
    chk("next_address", next_address, nx);
    chk("imem_req", imem_req, !m_boot && !m_halt);
    chk("irq_ack", irq_ack, xa);
    chk("halted", halted, m_halt);
    chk("epc", epc, m_epc);
    @(posedge clk);
    #1;
    if (xa) begin m_epc = m_pc; m_armed = 0; end
    else if (!q) m_armed = 1;
    if (m_boot) m_boot = 0;
    else if (m_halt) begin
      if (xa) m_halt = 0;
    end else if (adv) begin
      if (er == 0 && h) m_halt = 1;
      m_prank = 0; m_ptgt = 0;
    end else if (lr > m_prank) begin
      m_prank = lr; m_ptgt = lt;
    end
    m_pc = nx;
  endtask

  task automatic go_to(input int addr);
    cyc(1, 0, 0, 0, 1, addr, 0, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_next"}, next_address, RV);
    chk({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_irq_ack"}, irq_ack, 1'b0);
    chk({tag, "_halted"}, halted, 1'b0);
    chk({tag, "_epc"}, epc, 12'h000);
  endtask

  initial begin
    rst = 1; imem_ack = 0; stall = 0; branch_taken = 0; branch_target = '0;
    jump = 0; jump_target = '0; halt = 0; irq = 0;
    m_reset();
    @(posedge clk); #1;
    reset_checks("reset");
    rst = 0;

    // boot then sequential fetch 0,4,8,C,10
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", current_address, 12'(4 * k));
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
    end
    chk("seq_pc_10", current_address, 12'h010);

    // ack low 3 cycles, stall 2 cycles: hold at 'h010, then 'h014
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("hold_010", current_address, 12'h010);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("after_hold", current_address, 12'h014);

    // buffered branch then jump, and jump then branch: jump target wins
    go_to('h020);
    cyc(0, 0, 1, 'h100, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 'h200, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("br_then_jmp", current_address, 12'h200);
    go_to('h020);
    cyc(0, 0, 0, 0, 1, 'h200, 0, 0);
    cyc(0, 0, 1, 'h100, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("jmp_then_br", current_address, 12'h200);

    // interrupt beats jump; held irq does not re-enter until it drops
    go_to('h040);
    cyc(1, 0, 0, 0, 1, 'h300, 0, 1);
    chk("irq_pc", current_address, 12'h180);
    chk("irq_epc", epc, 12'h040);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("irq_rearm_pc", current_address, 12'h180);

    // halt freezes PC, ignores jumps; irq resumes
    go_to('h050);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0, k[0], 'h3A0, 0, 0);
    chk("halt_pc", current_address, 12'h050);
    chk("halt_flag", halted, 1'b1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("halt_irq_pc", current_address, 12'h180);
    chk("halt_irq_epc", epc, 12'h050);
    chk("halt_left", halted, 1'b0);

    // address wrap
    go_to('hFFC);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap", current_address, 12'h000);

    // asynchronous reset mid-fetch with a pending redirect
    go_to('h100);
    cyc(0, 0, 1, 'h234, 0, 0, 0, 0);
    rst = 1;
    #1;
    reset_checks("async_rst");
    chk("async_rst_pc", current_address, 12'h000);
    #1;
    rst = 0;
    m_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_seq", current_address, 12'h004);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
          $urandom_range(0, 19) < 3, int'($urandom_range(0, 4095)),
          $urandom_range(0, 9) < 1, int'($urandom_range(0, 4095)),
          $urandom_range(0, 19) < 1, $urandom_range(0, 11) < 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
